// File: rtl/me_candidate_engine.sv
// ---------------------------------------------------------------------------
// me_candidate_engine
//   3DRS candidate evaluator. For each block it builds up to NUM_CAND
//   candidate motion vectors (spatial A/B, temporal T, two updated vectors and
//   the zero vector), sends each to an external SAD datapath, and keeps the
//   candidate with the lowest penalised cost. If the winning SAD is still
//   above TH, a +/-1 extended search around the winner follows. The selected
//   MV is handed out over a valid/ready handshake.
//
// Ports
//   clk_i                 rising-edge clock
//   reset_i               synchronous reset, active low
//   start_i               1-cycle pulse, begins a block (ignored while busy)
//   mv_a_x_i/mv_a_y_i     spatial candidate A (left neighbour)
//   mv_b_x_i/mv_b_y_i     spatial candidate B (top neighbour)
//   mv_t_x_i/mv_t_y_i     temporal candidate T (previous frame)
//   cand_req_o            1-cycle pulse, cand_x_o/cand_y_o valid for SAD
//   cand_x_o/cand_y_o     candidate MV, stable until the next request
//   sad_valid_i           SAD result for the outstanding request
//   sad_in_i              SAD value
//   busy_o                block in progress
//   mv_valid_o            result valid, held until mv_ready_i
//   mv_ready_i            consumer accepts the result
//   mv_x_o/mv_y_o         selected MV
//   best_sad_o            raw SAD of the selected MV
//   ext_used_o            extended search ran for this block
// ---------------------------------------------------------------------------
module me_candidate_engine #(
    parameter int MV_W     = 7,
    parameter int SAD_W    = 16,
    parameter int NUM_CAND = 6,
    parameter int RANGE    = 31,
    parameter int PEN_T    = 8,
    parameter int PEN_UPD  = 32,
    parameter int EXT_EN   = 1,
    parameter int TH       = 512
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic signed [MV_W-1:0]  mv_a_x_i,
    input  logic signed [MV_W-1:0]  mv_a_y_i,
    input  logic signed [MV_W-1:0]  mv_b_x_i,
    input  logic signed [MV_W-1:0]  mv_b_y_i,
    input  logic signed [MV_W-1:0]  mv_t_x_i,
    input  logic signed [MV_W-1:0]  mv_t_y_i,
    output logic                    cand_req_o,
    output logic signed [MV_W-1:0]  cand_x_o,
    output logic signed [MV_W-1:0]  cand_y_o,
    input  logic                    sad_valid_i,
    input  logic        [SAD_W-1:0] sad_in_i,
    output logic                    busy_o,
    output logic                    mv_valid_o,
    input  logic                    mv_ready_i,
    output logic signed [MV_W-1:0]  mv_x_o,
    output logic signed [MV_W-1:0]  mv_y_o,
    output logic        [SAD_W-1:0] best_sad_o,
    output logic                    ext_used_o
);

    localparam int EW = MV_W + 1;
    localparam int CW = SAD_W + 1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_CAND - 1);
    localparam logic signed [EW-1:0] RMAX = EW'(RANGE);
    localparam logic signed [EW-1:0] RMIN = -RMAX;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_EXT_ISSUE, S_EXT_WAIT, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic        [2:0]       idx_q, idx_d;
    logic        [2:0]       ucnt_q, ucnt_d;
    logic        [2:0]       uidx_q, uidx_d;
    logic                    ext_q, ext_d;
    logic signed [MV_W-1:0]  aX_q, aX_d, aY_q, aY_d;
    logic signed [MV_W-1:0]  bX_q, bX_d, bY_q, bY_d;
    logic signed [MV_W-1:0]  tX_q, tX_d, tY_q, tY_d;
    logic signed [MV_W-1:0]  ctrX_q, ctrX_d, ctrY_q, ctrY_d;
    logic signed [MV_W-1:0]  bestX_q, bestX_d, bestY_q, bestY_d;
    logic        [SAD_W-1:0] bestSad_q, bestSad_d;
    logic        [CW-1:0]    bestCost_q, bestCost_d;

    logic signed [MV_W-1:0]  candX, candY;
    logic        [CW-1:0]    candPen, candCost;
    logic        [2:0]       uidxB;
    logic                    takeBest;
    logic signed [MV_W-1:0]  newX, newY;
    logic        [SAD_W-1:0] newSad;

    function automatic logic signed [MV_W-1:0] clampMv(input logic signed [EW-1:0] v);
        if (v > RMAX) return RMAX[MV_W-1:0];
        if (v < RMIN) return RMIN[MV_W-1:0];
        return v[MV_W-1:0];
    endfunction

    // Update table x/y components. Entries 0..3 double as the +/-1
    // neighbour offsets of the extended search.
    function automatic logic signed [2:0] updX(input logic [2:0] i);
        case (i)
            3'd0:    return 3'sd1;
            3'd1:    return -3'sd1;
            3'd4:    return 3'sd2;
            3'd5:    return -3'sd2;
            default: return 3'sd0;
        endcase
    endfunction

    function automatic logic signed [2:0] updY(input logic [2:0] i);
        case (i)
            3'd2:    return 3'sd1;
            3'd3:    return -3'sd1;
            3'd6:    return 3'sd2;
            3'd7:    return -3'sd2;
            default: return 3'sd0;
        endcase
    endfunction

    assign uidxB = uidx_q + 3'd4;

    // Candidate and penalty for the current index. Inputs are stored already
    // clamped, so only the sums need saturating here.
    always_comb begin
        candX   = '0;
        candY   = '0;
        candPen = '0;
        if (ext_q) begin
            candX = clampMv(EW'(ctrX_q) + EW'(updX({1'b0, idx_q[1:0]})));
            candY = clampMv(EW'(ctrY_q) + EW'(updY({1'b0, idx_q[1:0]})));
        end else begin
            case (idx_q)
                3'd0: begin candX = aX_q; candY = aY_q; end
                3'd1: begin candX = bX_q; candY = bY_q; end
                3'd2: begin candX = tX_q; candY = tY_q; candPen = CW'(PEN_T); end
                3'd3: begin
                    candX   = clampMv(EW'(aX_q) + EW'(updX(uidx_q)));
                    candY   = clampMv(EW'(aY_q) + EW'(updY(uidx_q)));
                    candPen = CW'(PEN_UPD);
                end
                3'd4: begin
                    candX   = clampMv(EW'(bX_q) + EW'(updX(uidxB)));
                    candY   = clampMv(EW'(bY_q) + EW'(updY(uidxB)));
                    candPen = CW'(PEN_UPD);
                end
                default: begin candX = '0; candY = '0; end
            endcase
        end
    end

    assign candCost = {1'b0, sad_in_i} + candPen;
    assign takeBest = sad_valid_i && (candCost < bestCost_q) &&
                      ((state_q == S_WAIT) || (state_q == S_EXT_WAIT));
    assign newX     = takeBest ? candX : bestX_q;
    assign newY     = takeBest ? candY : bestY_q;
    assign newSad   = takeBest ? sad_in_i : bestSad_q;

    // Next-state logic: sequencing of the candidate and extended phases.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ucnt_d     = ucnt_q;
        uidx_d     = uidx_q;
        ext_d      = ext_q;
        aX_d       = aX_q;
        aY_d       = aY_q;
        bX_d       = bX_q;
        bY_d       = bY_q;
        tX_d       = tX_q;
        tY_d       = tY_q;
        ctrX_d     = ctrX_q;
        ctrY_d     = ctrY_q;
        bestX_d    = bestX_q;
        bestY_d    = bestY_q;
        bestSad_d  = bestSad_q;
        bestCost_d = bestCost_q;
        if (takeBest) begin
            bestX_d    = candX;
            bestY_d    = candY;
            bestSad_d  = sad_in_i;
            bestCost_d = candCost;
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    aX_d       = clampMv(EW'(mv_a_x_i));
                    aY_d       = clampMv(EW'(mv_a_y_i));
                    bX_d       = clampMv(EW'(mv_b_x_i));
                    bY_d       = clampMv(EW'(mv_b_y_i));
                    tX_d       = clampMv(EW'(mv_t_x_i));
                    tY_d       = clampMv(EW'(mv_t_y_i));
                    uidx_d     = ucnt_q;
                    ucnt_d     = ucnt_q + 3'd1;
                    idx_d      = '0;
                    ext_d      = 1'b0;
                    bestCost_d = '1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_WAIT;
            S_EXT_ISSUE: state_d = S_EXT_WAIT;
            S_WAIT: begin
                if (sad_valid_i) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_ISSUE;
                    end else if ((EXT_EN != 0) && (32'(newSad) > 32'(TH))) begin
                        ctrX_d  = newX;
                        ctrY_d  = newY;
                        idx_d   = '0;
                        ext_d   = 1'b1;
                        state_d = S_EXT_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_EXT_WAIT: begin
                if (sad_valid_i) begin
                    if (idx_q[1:0] == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_EXT_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (mv_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            idx_q      <= '0;
            ucnt_q     <= '0;
            uidx_q     <= '0;
            ext_q      <= 1'b0;
            aX_q       <= '0;
            aY_q       <= '0;
            bX_q       <= '0;
            bY_q       <= '0;
            tX_q       <= '0;
            tY_q       <= '0;
            ctrX_q     <= '0;
            ctrY_q     <= '0;
            bestX_q    <= '0;
            bestY_q    <= '0;
            bestSad_q  <= '0;
            bestCost_q <= '0;
        end else begin
            idx_q      <= idx_d;
            ucnt_q     <= ucnt_d;
            uidx_q     <= uidx_d;
            ext_q      <= ext_d;
            aX_q       <= aX_d;
            aY_q       <= aY_d;
            bX_q       <= bX_d;
            bY_q       <= bY_d;
            tX_q       <= tX_d;
            tY_q       <= tY_d;
            ctrX_q     <= ctrX_d;
            ctrY_q     <= ctrY_d;
            bestX_q    <= bestX_d;
            bestY_q    <= bestY_d;
            bestSad_q  <= bestSad_d;
            bestCost_q <= bestCost_d;
        end
    end

    assign cand_req_o = (state_q == S_ISSUE) || (state_q == S_EXT_ISSUE);
    assign cand_x_o   = candX;
    assign cand_y_o   = candY;
    assign busy_o     = (state_q != S_IDLE);
    assign mv_valid_o = (state_q == S_DONE);
    assign mv_x_o     = bestX_q;
    assign mv_y_o     = bestY_q;
    assign best_sad_o = bestSad_q;
    assign ext_used_o = ext_q;

endmodule

// File: tb/tb_me_candidate_engine.sv
// ---------------------------------------------------------------------------
// tb_me_candidate_engine
//   Directed bench for me_candidate_engine with default parameters. A small
//   SAD responder feeds scripted SAD values back after a chosen latency and
//   records every issued candidate for comparison with hand-computed values.
// ---------------------------------------------------------------------------
module tb_me_candidate_engine;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [6:0]   mv_a_x, mv_a_y, mv_b_x, mv_b_y, mv_t_x, mv_t_y;
    logic                cand_req;
    logic signed [6:0]   cand_x, cand_y;
    logic                sad_valid;
    logic        [15:0]  sad_in;
    logic                busy;
    logic                mv_valid;
    logic                mv_ready;
    logic signed [6:0]   mv_x, mv_y;
    logic        [15:0]  best_sad;
    logic                ext_used;

    int checks = 0;
    int errors = 0;

    int sadQ   [16];
    int candXs [16];
    int candYs [16];
    int nCand;
    int latency;

    int tabX [8] = '{1, -1, 0, 0, 2, -2, 0, 0};
    int tabY [8] = '{0, 0, 1, -1, 0, 0, 2, -2};

    me_candidate_engine dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .mv_a_x_i    (mv_a_x),
        .mv_a_y_i    (mv_a_y),
        .mv_b_x_i    (mv_b_x),
        .mv_b_y_i    (mv_b_y),
        .mv_t_x_i    (mv_t_x),
        .mv_t_y_i    (mv_t_y),
        .cand_req_o  (cand_req),
        .cand_x_o    (cand_x),
        .cand_y_o    (cand_y),
        .sad_valid_i (sad_valid),
        .sad_in_i    (sad_in),
        .busy_o      (busy),
        .mv_valid_o  (mv_valid),
        .mv_ready_i  (mv_ready),
        .mv_x_o      (mv_x),
        .mv_y_o      (mv_y),
        .best_sad_o  (best_sad),
        .ext_used_o  (ext_used)
    );

    // 10 ns clock; the bench drives and samples on the falling edge.
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // All outputs must read as zero / idle.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " cand_req"}, int'(cand_req), 0);
        checkOutput({tag, " cand_x"},   int'(cand_x),   0);
        checkOutput({tag, " cand_y"},   int'(cand_y),   0);
        checkOutput({tag, " busy"},     int'(busy),     0);
        checkOutput({tag, " mv_valid"}, int'(mv_valid), 0);
        checkOutput({tag, " mv_x"},     int'(mv_x),     0);
        checkOutput({tag, " mv_y"},     int'(mv_y),     0);
        checkOutput({tag, " best_sad"}, int'(best_sad), 0);
        checkOutput({tag, " ext_used"}, int'(ext_used), 0);
    endtask

    task automatic checkResult(input string tag, input int ex, input int ey,
                               input int es, input int eext);
        checkOutput({tag, " mv_x"},     int'(mv_x),     ex);
        checkOutput({tag, " mv_y"},     int'(mv_y),     ey);
        checkOutput({tag, " best_sad"}, int'(best_sad), es);
        checkOutput({tag, " ext_used"}, int'(ext_used), eext);
    endtask

    task automatic checkCand(input string tag, input int i, input int ex, input int ey);
        checkOutput({tag, " cand_x"}, candXs[i], ex);
        checkOutput({tag, " cand_y"}, candYs[i], ey);
    endtask

    // Runs one block: pulses start, answers each cand_req with the next
    // scripted SAD after 1..maxLat cycles, and returns once mv_valid is seen.
    // With busyStarts set, extra start pulses (with a different A) are
    // driven while the block is running. Called and returns on a falling edge.
    task automatic applyStimulus(input int ax, input int ay, input int bx, input int by,
                                 input int tx, input int ty, input int maxLat,
                                 input bit busyStarts);
        int waitCnt = 0;
        int nS = 0;
        int cyc = 0;
        bit done = 1'b0;
        mv_a_x = 7'(ax); mv_a_y = 7'(ay);
        mv_b_x = 7'(bx); mv_b_y = 7'(by);
        mv_t_x = 7'(tx); mv_t_y = 7'(ty);
        start  = 1'b1;
        nCand  = 0;
        latency = -1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            sad_valid = 1'b0;
            mv_a_x    = 7'(ax);
            if (mv_valid) begin
                latency = cyc;
                done    = 1'b1;
            end else begin
                if (cand_req) begin
                    if (nCand < 16) begin
                        candXs[nCand] = int'(cand_x);
                        candYs[nCand] = int'(cand_y);
                    end
                    nCand++;
                    waitCnt = (maxLat > 1) ? int'($urandom_range(maxLat, 1)) : 1;
                end else if (waitCnt > 0) begin
                    waitCnt--;
                    if (waitCnt == 0) begin
                        sad_valid = 1'b1;
                        sad_in    = (nS < 16) ? 16'(sadQ[nS]) : 16'd0;
                        nS++;
                    end
                end
                if (busyStarts && (cyc % 3 == 0)) begin
                    start  = 1'b1;
                    mv_a_x = 7'sd20;
                end
            end
        end
        start  = 1'b0;
        mv_a_x = 7'(ax);
        checkOutput("mv_valid reached", int'(done), 1);
    endtask

    // Holds mv_ready low for some cycles, then accepts the result.
    task automatic finishBlock(input int hold, input int ex, input int ey);
        for (int i = 0; i < hold; i++) begin
            mv_ready = 1'b0;
            @(negedge clk);
            checkOutput("hold mv_valid", int'(mv_valid), 1);
            checkOutput("hold mv_x", int'(mv_x), ex);
            checkOutput("hold mv_y", int'(mv_y), ey);
        end
        mv_ready = 1'b1;
        @(negedge clk);
        mv_ready = 1'b0;
        checkOutput("release mv_valid", int'(mv_valid), 0);
        checkOutput("release busy", int'(busy), 0);
    endtask

    task automatic fillSad(input int v);
        for (int i = 0; i < 16; i++) sadQ[i] = v;
    endtask

    task automatic loadBasicSads();
        fillSad(0);
        sadQ[0] = 100; sadQ[1] = 95; sadQ[2] = 85;
        sadQ[3] = 200; sadQ[4] = 200; sadQ[5] = 96;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; sad_valid = 1'b0; sad_in = '0; mv_ready = 1'b0;
        mv_a_x = '0; mv_a_y = '0; mv_b_x = '0; mv_b_y = '0; mv_t_x = '0; mv_t_y = '0;
        repeat (3) @(negedge clk);
        checkIdle("por");
        reset = 1'b1;
        @(negedge clk);

        // T1: reset in the middle of a WAIT; a late SAD must not restart anything.
        mv_a_x = 7'sd7; mv_a_y = 7'sd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t1 cand_req", int'(cand_req), 1);
        checkOutput("t1 busy", int'(busy), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("t1 reset");
        reset = 1'b1; sad_valid = 1'b1; sad_in = 16'd5;
        @(negedge clk);
        sad_valid = 1'b0;
        checkIdle("t1 late sad");
        @(negedge clk);
        checkOutput("t1 still idle", int'(busy), 0);

        // T2: basic selection, temporal candidate wins with cost 85+8=93.
        loadBasicSads();
        applyStimulus(3, 2, 0, 1, 3, 2, 1, 1'b0);
        checkOutput("t2 latency", latency, 13);
        checkOutput("t2 ncand", nCand, 6);
        checkResult("t2", 3, 2, 85, 0);
        checkCand("t2 c1", 1, 0, 1);
        checkCand("t2 c3", 3, 4, 2);
        checkCand("t2 c4", 4, 2, 1);
        checkCand("t2 c5", 5, 0, 0);
        finishBlock(2, 3, 2);

        // T3: equal SADs, earliest zero-penalty candidate wins; clamping.
        fillSad(50);
        applyStimulus(-40, 5, 40, -50, 2, 2, 1, 1'b0);
        checkCand("t3 c0", 0, -31, 5);
        checkCand("t3 c1", 1, 31, -31);
        checkCand("t3 c3", 3, -31, 5);
        checkCand("t3 c4", 4, 29, -31);
        checkResult("t3", -31, 5, 50, 0);
        finishBlock(2, -31, 5);

        // T4: best SAD 600 > 512 triggers the +/-1 search around (5,5).
        fillSad(700);
        sadQ[0] = 600; sadQ[6] = 700; sadQ[7] = 580; sadQ[8] = 650; sadQ[9] = 610;
        applyStimulus(5, 5, 10, 10, -3, -3, 1, 1'b0);
        checkOutput("t4 latency", latency, 21);
        checkOutput("t4 ncand", nCand, 10);
        checkCand("t4 c3", 3, 5, 6);
        checkCand("t4 c4", 4, 10, 12);
        checkCand("t4 e0", 6, 6, 5);
        checkCand("t4 e1", 7, 4, 5);
        checkCand("t4 e2", 8, 5, 6);
        checkCand("t4 e3", 9, 5, 4);
        checkResult("t4", 4, 5, 580, 1);
        finishBlock(2, 4, 5);

        // T5: update counter is at 3 after three accepted blocks; nine blocks
        // walk the whole table and wrap back.
        for (int k = 0; k < 9; k++) begin
            int u;
            u = (3 + k) % 8;
            fillSad(10);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 1'b0);
            checkCand("t5 uA", 3, tabX[u], tabY[u]);
            checkCand("t5 uB", 4, tabX[(u + 4) % 8], tabY[(u + 4) % 8]);
            checkResult("t5", 0, 0, 10, 0);
            finishBlock(0, 0, 0);
        end

        // T6: random SAD latency, stray starts while busy, backpressure.
        loadBasicSads();
        applyStimulus(3, 2, 0, 1, 3, 2, 7, 1'b1);
        checkOutput("t6 ncand", nCand, 6);
        checkCand("t6 c0", 0, 3, 2);
        checkCand("t6 c3", 3, 5, 2);
        checkCand("t6 c4", 4, 1, 1);
        checkResult("t6", 3, 2, 85, 0);
        finishBlock(10, 3, 2);

        // The stray starts must not have advanced the update counter.
        fillSad(10);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1'b0);
        checkCand("t6 ucnt uA", 3, -2, 0);
        checkCand("t6 ucnt uB", 4, -1, 0);
        finishBlock(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
